// File: rtl/rx_timestamp_stamper.sv
// rx_timestamp_stamper
//
// Receive-side AXI-Stream stage in front of a per-port arbiter input. It runs
// a free-running timestamp counter and, when stamp_en is set at the moment a
// packet's first beat is accepted, writes the counter value into the
// timestamp field of that beat's tuser. Every beat is otherwise passed
// bit-exact through a two-entry skid buffer (OUT + SKID). The buffer gives
// full throughput with a registered s_axis_tready.
//
// Handshake: a beat moves across an interface on a clock edge where tvalid
// and tready are both high. A producer holding tvalid keeps its payload
// stable and never drops tvalid before that edge. tready may depend on
// anything and may change freely.
//
// Ports
//   axi_aclk        sole clock
//   axi_aresetn     asynchronous active-low reset
//   sw_rst          synchronous active-high soft reset; flushes buffered beats
//   stamp_en        1 = stamp first beats, 0 = tuser passes unchanged
//   s_axis_*        input stream: tdata/tstrb/tuser/tvalid/tlast in, tready out
//   m_axis_*        output stream: tdata/tstrb/tuser/tvalid/tlast out, tready in
//   ts_now          current timestamp counter value
//
// The slave and master widths must match. The C_S_* and C_M_* pairs exist
// only so the port list lines up with the neighbouring cores.

module rx_timestamp_stamper #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TUSER_TIMESTAMP_POS = 32,
    parameter int TIMESTAMP_WIDTH       = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              sw_rst,
    input  logic                              stamp_en,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [TIMESTAMP_WIDTH-1:0]        ts_now
);

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;

    logic          in_pkt;        // 1 while inside a packet (first beat already taken)
    logic          ready_q;       // registered !SKID.valid
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic [SW-1:0] skid_strb;
    logic [UW-1:0] skid_user;
    logic          skid_last;

    logic          accept;
    logic          out_take;      // OUT is empty or drains this cycle
    logic          skid_valid_next;
    logic [UW-1:0] in_user;

    // sw_rst gates tready directly so no beat is taken during the soft reset
    // cycle itself, not just from the following cycle.
    assign s_axis_tready = ready_q && !sw_rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_take      = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        in_user = s_axis_tuser;
        if (!in_pkt && stamp_en) begin
            in_user[C_TUSER_TIMESTAMP_POS +: TIMESTAMP_WIDTH] = ts_now;
        end
    end

    // SKID holds a beat only while OUT is stalled. Accept cannot coincide
    // with skid_valid because tready is low whenever SKID is occupied.
    always_comb begin
        if (skid_valid) begin
            skid_valid_next = !out_take;
        end else begin
            skid_valid_next = accept && !out_take;
        end
    end

    // Timestamp counter; wraps naturally at 2^TIMESTAMP_WIDTH.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ts_now <= '0;
        end else if (sw_rst) begin
            ts_now <= '0;
        end else begin
            ts_now <= ts_now + TIMESTAMP_WIDTH'(1);
        end
    end

    // Packet position and input-ready register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            in_pkt  <= 1'b0;
            ready_q <= 1'b0;
        end else if (sw_rst) begin
            in_pkt  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= !skid_valid_next;
            if (accept) begin
                in_pkt <= !s_axis_tlast;
            end
        end
    end

    // OUT register: refilled from SKID first (oldest beat), else from input.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (sw_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_take) begin
            m_axis_tvalid <= skid_valid || accept;
            if (skid_valid) begin
                m_axis_tdata <= skid_data;
                m_axis_tstrb <= skid_strb;
                m_axis_tuser <= skid_user;
                m_axis_tlast <= skid_last;
            end else if (accept) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tstrb <= s_axis_tstrb;
                m_axis_tuser <= in_user;
                m_axis_tlast <= s_axis_tlast;
            end
        end
    end

    // SKID register: captures an accepted beat while OUT is stalled.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_strb  <= '0;
            skid_user  <= '0;
            skid_last  <= 1'b0;
        end else if (sw_rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_strb  <= '0;
            skid_user  <= '0;
            skid_last  <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            if (accept && !out_take) begin
                skid_data <= s_axis_tdata;
                skid_strb <= s_axis_tstrb;
                skid_user <= in_user;
                skid_last <= s_axis_tlast;
            end
        end
    end

endmodule

// File: tb/tb_rx_timestamp_stamper.sv
// Testbench for rx_timestamp_stamper.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// either at that point (post-edge state) or at the falling edge (scoreboard
// monitor and acceptance capture). A second instance with a 12-bit timestamp
// exercises the counter wrap, which is out of reach for the 32-bit default.

module tb_rx_timestamp_stamper;

    localparam int DW   = 256;
    localparam int SW   = DW / 8;
    localparam int UW   = 128;
    localparam int POS  = 32;
    localparam int TW   = 32;
    localparam int TWW  = 12;
    localparam int SBW  = 1 + SW + UW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_rst = 1'b0;
    logic stamp_en = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0]  s_tdata = '0;
    logic [SW-1:0]  s_tstrb = '0;
    logic [UW-1:0]  s_tuser = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tlast = 1'b0;
    logic           s_tready;
    logic [DW-1:0]  m_tdata;
    logic [SW-1:0]  m_tstrb;
    logic [UW-1:0]  m_tuser;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready = 1'b1;
    logic [TW-1:0]  ts_now;

    logic           w_s_tready;
    logic [DW-1:0]  w_tdata;
    logic [SW-1:0]  w_tstrb;
    logic [UW-1:0]  w_tuser;
    logic           w_tvalid;
    logic           w_tlast;
    logic [TWW-1:0] w_ts_now;

    rx_timestamp_stamper u_dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .sw_rst        (sw_rst),
        .stamp_en      (stamp_en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .ts_now        (ts_now)
    );

    rx_timestamp_stamper #(.TIMESTAMP_WIDTH(TWW)) u_dut_wrap (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .sw_rst        (sw_rst),
        .stamp_en      (stamp_en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (w_s_tready),
        .m_axis_tdata  (w_tdata),
        .m_axis_tstrb  (w_tstrb),
        .m_axis_tuser  (w_tuser),
        .m_axis_tvalid (w_tvalid),
        .m_axis_tlast  (w_tlast),
        .m_axis_tready (m_tready),
        .ts_now        (w_ts_now)
    );

    // ---------------- scoreboard state ----------------
    int             errors = 0;
    int             checks = 0;
    logic [TW-1:0]  exp_ts = '0;
    bit             mdl_in_pkt = 1'b0;
    logic [SBW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int i);
        logic [31:0] k;
        k = 32'(i);
        return {8{32'hD000_0000 + k}};
    endfunction

    function automatic logic [UW-1:0] usr(input int i);
        logic [31:0] k;
        k = 32'(i);
        return {32'h1111_0000 + k, 32'h2222_0000 + k, 32'h3333_0000 + k, 32'h4444_0000 + k};
    endfunction

    // One clock: monitor the output handshake and capture any input
    // acceptance at the falling edge, then advance past the rising edge.
    task automatic cycle(output bit acc);
        logic [SBW-1:0] e;
        logic [UW-1:0]  u;
        bit             swr;
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            check("sb_beat_expected", 256'(exp_q.size() != 0), 256'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_tdata", m_tdata, e[DW-1:0]);
                check("sb_tuser", 256'(m_tuser), 256'(e[DW +: UW]));
                check("sb_tstrb", 256'(m_tstrb), 256'(e[DW+UW +: SW]));
                check("sb_tlast", 256'(m_tlast), 256'(e[SBW-1]));
            end
        end
        acc = s_tvalid && s_tready;
        if (acc) begin
            u = s_tuser;
            if (!mdl_in_pkt && stamp_en) u[POS +: TW] = exp_ts;
            exp_q.push_back({s_tlast, s_tstrb, u, s_tdata});
            mdl_in_pkt = !s_tlast;
        end
        swr = sw_rst;
        @(posedge clk);
        #1;
        if (swr) begin
            exp_ts = '0;
            mdl_in_pkt = 1'b0;
            exp_q.delete();
        end else begin
            exp_ts = exp_ts + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(acc);
    endtask

    task automatic send_raw(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic last);
        bit acc;
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tstrb  = d[SW-1:0] ^ 32'h5A5A_5A5A;
        s_tlast  = last;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            cycle(acc);
            n++;
        end
        check("send_accepted", 256'(acc), 256'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic send(input int i, input logic last);
        send_raw(dat(i), usr(i), last);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic a_reset();
        rst_n = 1'b0;
        #2;
        check("arst_m_tvalid", 256'(m_tvalid), 256'd0);
        check("arst_s_tready", 256'(s_tready), 256'd0);
        check("arst_m_tdata", m_tdata, 256'd0);
        check("arst_m_tuser", 256'(m_tuser), 256'd0);
        check("arst_ts_now", 256'(ts_now), 256'd0);
        check("arst_w_ts_now", 256'(w_ts_now), 256'd0);
        exp_ts = '0;
        mdl_in_pkt = 1'b0;
        exp_q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        @(posedge clk);
        #1;
        a_reset();
        cycle(acc);
        check("ready_after_reset", 256'(s_tready), 256'd1);
        check("ts_after_1clk", 256'(ts_now), 256'd1);

        // Single-beat packet stamped at ts_now = 0x10.
        stamp_en = 1'b1;
        while (exp_ts != 32'h10) cycle(acc);
        check("ts_before_single", 256'(ts_now), 256'h10);
        send_raw(dat(1), '0, 1'b1);
        check("single_tvalid", 256'(m_tvalid), 256'd1);
        check("single_tlast", 256'(m_tlast), 256'd1);
        check("single_tuser", 256'(m_tuser), 256'h0000_0010_0000_0000);
        idle(2);

        // Four-beat packet back to back, first beat at ts_now = 0x20.
        while (exp_ts != 32'h20) cycle(acc);
        for (int i = 0; i < 4; i++) begin
            send(i, i == 3);
            check("b2b_tvalid", 256'(m_tvalid), 256'd1);
            if (i == 0) check("b2b_tuser0", 256'(m_tuser), 256'h1111_0000_2222_0000_0000_0020_4444_0000);
            else        check("b2b_tuser", 256'(m_tuser), 256'(usr(i)));
        end
        idle(2);

        // stamp_en = 0: tuser bit-exact.
        stamp_en = 1'b0;
        send(4, 1'b0);
        check("nostamp_tuser0", 256'(m_tuser), 256'(usr(4)));
        send(5, 1'b0);
        send(6, 1'b1);
        // Enabled at first beat, toggled mid-packet.
        stamp_en = 1'b1;
        send(7, 1'b0);
        stamp_en = 1'b0;
        send(8, 1'b0);
        check("toggle_tuser1", 256'(m_tuser), 256'(usr(8)));
        stamp_en = 1'b1;
        send(9, 1'b1);
        check("toggle_tuser2", 256'(m_tuser), 256'(usr(9)));
        // Disabled at first beat, enabled mid-packet: nothing stamped.
        stamp_en = 1'b0;
        send(10, 1'b0);
        check("late_en_tuser0", 256'(m_tuser), 256'(usr(10)));
        stamp_en = 1'b1;
        send(11, 1'b1);
        check("late_en_tuser1", 256'(m_tuser), 256'(usr(11)));
        idle(2);

        // Backpressure: m_tready low for 5 cycles during a continuous stream.
        send(20, 1'b0);
        m_tready = 1'b0;
        send(21, 1'b0);
        check("bp_ready_low", 256'(s_tready), 256'd0);
        check("bp_hold_tdata", m_tdata, dat(20));
        s_tvalid = 1'b1;
        s_tdata  = dat(22);
        s_tuser  = usr(22);
        s_tstrb  = dat(22)[SW-1:0] ^ 32'h5A5A_5A5A;
        s_tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            check("bp_no_accept", 256'(acc), 256'd0);
            check("bp_ready_held", 256'(s_tready), 256'd0);
            check("bp_tvalid", 256'(m_tvalid), 256'd1);
            check("bp_hold_tdata", m_tdata, dat(20));
            check("bp_hold_tlast", 256'(m_tlast), 256'd0);
        end
        m_tready = 1'b1;
        for (int i = 22; i < 26; i++) begin
            send(i, i == 25);
            check("bp_no_gap", 256'(m_tvalid), 256'd1);
        end
        idle(3);

        // Asynchronous reset in the middle of a 4-beat packet.
        send(30, 1'b0);
        send(31, 1'b0);
        a_reset();
        cycle(acc);
        check("arst_ready_back", 256'(s_tready), 256'd1);
        send(40, 1'b1);
        check("arst_restamp", 256'(m_tuser), 256'h1111_0028_2222_0028_0000_0001_4444_0028);
        idle(2);

        // Soft reset in the middle of a 4-beat packet.
        send(50, 1'b0);
        send(51, 1'b0);
        sw_rst = 1'b1;
        #1;
        check("swrst_ready_low", 256'(s_tready), 256'd0);
        cycle(acc);
        check("swrst_m_tvalid", 256'(m_tvalid), 256'd0);
        check("swrst_m_tdata", m_tdata, 256'd0);
        check("swrst_ts_now", 256'(ts_now), 256'd0);
        sw_rst = 1'b0;
        cycle(acc);
        check("swrst_ready_back", 256'(s_tready), 256'd1);
        send(60, 1'b1);
        check("swrst_restamp", 256'(m_tuser), 256'h1111_003C_2222_003C_0000_0001_4444_003C);
        idle(2);

        // Counter wrap on the 12-bit instance: accept at 0xFFF.
        a_reset();
        while (exp_ts != 32'hFFF) cycle(acc);
        check("wrap_ts_before", 256'(w_ts_now), 256'hFFF);
        send_raw(dat(70), '0, 1'b1);
        check("wrap_tvalid", 256'(w_tvalid), 256'd1);
        check("wrap_tuser", 256'(w_tuser), 256'h0FFF_0000_0000);
        check("wrap_ts_after", 256'(w_ts_now), 256'd0);
        check("nowrap_ts_main", 256'(ts_now), 256'h1000);
        idle(3);

        check("sb_drained", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
